// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry block: key codes, operator
// encoding, FSM state types and small key classification helpers.
package keypad_pkg;

  // Key codes delivered by the keypad scanner
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  // Operator encoding presented to the calculator core
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Entry FSM: editing A, editing B, request outstanding
  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_REQ = 2'd2
  } state_t;

  // Debouncer state
  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_t;

  function automatic logic is_digit(input logic [3:0] c);
    return (c <= 4'd9);
  endfunction

  function automatic logic is_oper(input logic [3:0] c);
    return (c >= KEY_ADD) && (c <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the operator is the offset from KEY_ADD
  function automatic logic [1:0] key_to_op(input logic [3:0] c);
    return 2'(c - KEY_ADD);
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Request bus between the keypad entry block (master) and the
// calculator core (slave): operands, operator and req/ready handshake.
interface keypad_entry_if #(
  parameter int DIGITS = 4
);

  logic                  calc_req;
  logic                  calc_ready;
  logic [4*DIGITS-1:0]   operand_a;
  logic [4*DIGITS-1:0]   operand_b;
  logic [1:0]            op;

  modport master (
    output calc_req,
    output operand_a,
    output operand_b,
    output op,
    input  calc_ready
  );

  modport slave (
    input  calc_req,
    input  operand_a,
    input  operand_b,
    input  op,
    output calc_ready
  );

endinterface

// File: rtl/keypad_entry_key_debounce.sv
// Key debouncer: a press is accepted after DEBOUNCE_CYCLES consecutive
// cycles of key_down=1 with a steady key_code, a release after the same
// number of cycles of key_down=0. Each accepted press yields one
// single-cycle event carrying the key code; holding never repeats.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_down,
  output logic       key_evt,
  output logic [3:0] key_evt_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          evt_q, evt_d;
  logic [3:0]    evt_code_q, evt_code_d;

  // Next-state: count the length of the current stable run
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    evt_d      = 1'b0;
    evt_code_d = evt_code_q;
    case (state_q)
      DB_RELEASED: begin
        if (!key_down) begin
          cnt_d = '0;
        end else begin
          // A fresh press or a code change starts a new run at length 1
          if ((cnt_q == '0) || (key_code != code_q)) begin
            code_d = key_code;
            cnt_d  = CW'(1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_d >= TARGET) begin
            state_d    = DB_PRESSED;
            cnt_d      = '0;
            evt_d      = 1'b1;
            evt_code_d = code_d;
          end
        end
      end
      DB_PRESSED: begin
        if (key_down) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d >= TARGET) begin
            state_d = DB_RELEASED;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = DB_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DB_RELEASED;
      cnt_q      <= '0;
      code_q     <= '0;
      evt_q      <= 1'b0;
      evt_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      evt_q      <= evt_d;
      evt_code_q <= evt_code_d;
    end
  end

  assign key_evt      = evt_q;
  assign key_evt_code = evt_code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: turns debounced key events into BCD operands A and B and
// an operator, then requests a calculation with a req/ready handshake.
// Optional build macro ENTRY_BACKSPACE_EN makes the clear key delete the
// last digit of a non-empty operand instead of clearing everything.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           key_code,
  input  logic                 key_down,
  keypad_entry_if.master       calc,
  output logic [4*DIGITS-1:0]  entry_bcd,
  output logic                 entry_ovf
);

  localparam int W    = 4 * DIGITS;
  localparam int CNTW = $clog2(DIGITS + 1);
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(DIGITS);

  logic       evt;
  logic [3:0] evt_code;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .key_code     (key_code),
    .key_down     (key_down),
    .key_evt      (evt),
    .key_evt_code (evt_code)
  );

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, entry_q, entry_d;
  logic [CNTW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]      op_q, op_d;
  logic            req_q, req_d;
  logic            ovf_q, ovf_d;

  // Working copy of whichever operand is being edited
  logic            in_b;
  logic [W-1:0]    tgt, tgt_d;
  logic [CNTW-1:0] tcnt, tcnt_d;
  logic            full_clr;

  // Next-state: apply the key event, then the handshake, then clears
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_d     = op_q;
    req_d    = req_q;
    ovf_d    = ovf_q;
    full_clr = 1'b0;

    in_b   = (state_q != S_A);
    tgt    = in_b ? b_q : a_q;
    tcnt   = in_b ? cnt_b_q : cnt_a_q;
    tgt_d  = tgt;
    tcnt_d = tcnt;

    if (evt) begin
      if (evt_code == KEY_CLR) begin
`ifdef ENTRY_BACKSPACE_EN
        if ((state_q != S_REQ) && (tcnt != '0)) begin
          tgt_d  = tgt >> 4;
          tcnt_d = tcnt - 1'b1;
          ovf_d  = 1'b0;
        end else begin
          full_clr = 1'b1;
        end
`else
        full_clr = 1'b1;
`endif
      end else if (state_q != S_REQ) begin
        if (is_digit(evt_code)) begin
          if (tcnt < MAX_CNT) begin
            tgt_d  = (tgt << 4) | W'(evt_code);
            tcnt_d = tcnt + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (is_oper(evt_code)) begin
          if (state_q == S_A) begin
            op_d    = key_to_op(evt_code);
            state_d = S_B;
          end else if (cnt_b_q == '0) begin
            op_d = key_to_op(evt_code);
          end
        end else if ((evt_code == KEY_EQ) && (state_q == S_B)) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
    end

    if (in_b) begin
      b_d     = tgt_d;
      cnt_b_d = tcnt_d;
    end else begin
      a_d     = tgt_d;
      cnt_a_d = tcnt_d;
    end

    // A completed handshake returns to a clean S_A and wins over any key
    if (req_q && calc.calc_ready) begin
      full_clr = 1'b1;
    end

    if (full_clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = OP_ADD;
      req_d   = 1'b0;
      ovf_d   = 1'b0;
    end

    entry_d = (state_d == S_A) ? a_d : b_d;
  end

  // Entry FSM and registered outputs with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      op_q    <= OP_ADD;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      op_q    <= op_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
      entry_q <= entry_d;
    end
  end

  assign calc.calc_req  = req_q;
  assign calc.operand_a = a_q;
  assign calc.operand_b = b_q;
  assign calc.op        = op_q;
  assign entry_bcd      = entry_q;
  assign entry_ovf      = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with DIGITS=4, DEBOUNCE_CYCLES=4.
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int DIGITS = 4;
  localparam int DB     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] entry_bcd;
  logic        entry_ovf;

  int checks   = 0;
  int failures = 0;

  keypad_entry_if #(.DIGITS(DIGITS)) calc_bus ();

  keypad_entry #(
    .DIGITS          (DIGITS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_down  (key_down),
    .calc      (calc_bus),
    .entry_bcd (entry_bcd),
    .entry_ovf (entry_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_code = c;
    key_down = 1'b1;
    repeat (6) tick();
    key_down = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   32'(calc_bus.calc_req),  32'h0);
    check({tag, "_a"},     32'(calc_bus.operand_a), 32'h0);
    check({tag, "_b"},     32'(calc_bus.operand_b), 32'h0);
    check({tag, "_op"},    32'(calc_bus.op),        32'h0);
    check({tag, "_entry"}, 32'(entry_bcd),          32'h0);
    check({tag, "_ovf"},   32'(entry_ovf),          32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int h;

    rst                 = 1'b1;
    key_code            = 4'h0;
    key_down            = 1'b0;
    calc_bus.calc_ready = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Press 1 with latency check, then 2 and 3
    key_code = 4'h1;
    key_down = 1'b1;
    repeat (DB) tick();
    check("lat_before", 32'(entry_bcd), 32'h0);
    tick();
    check("lat_after", 32'(entry_bcd), 32'h1);
    tick();
    key_down = 1'b0;
    repeat (6) tick();
    press(4'h2);
    check("press2_entry", 32'(entry_bcd), 32'h12);
    press(4'h3);
    check("press3_entry", 32'(entry_bcd), 32'h0123);
    check("press3_a", 32'(calc_bus.operand_a), 32'h0123);

    // Glitch of 3 cycles: no event
    key_code = 4'h5;
    key_down = 1'b1;
    repeat (3) tick();
    key_down = 1'b0;
    repeat (6) tick();
    check("glitch_entry", 32'(entry_bcd), 32'h0123);

    // Code changes mid-hold restart the run: 2 + 3 cycles, no event
    key_code = 4'h6;
    key_down = 1'b1;
    repeat (2) tick();
    key_code = 4'h7;
    repeat (3) tick();
    key_down = 1'b0;
    repeat (6) tick();
    check("restart_entry", 32'(entry_bcd), 32'h0123);

    // 4 2 + 7 = with delayed ready
    do_reset();
    press(4'h4);
    press(4'h2);
    press(KEY_ADD);
    check("opA_entry", 32'(entry_bcd), 32'h0);
    check("opA_a", 32'(calc_bus.operand_a), 32'h0042);
    press(4'h7);
    check("b7_entry", 32'(entry_bcd), 32'h7);
    key_code = KEY_EQ;
    key_down = 1'b1;
    n = 0;
    while (!calc_bus.calc_req && n < 20) begin
      tick();
      n++;
    end
    check("req_latency", 32'(n), 32'd5);
    h = calc_bus.calc_req ? 1 : 0;
    check("req_a", 32'(calc_bus.operand_a), 32'h0042);
    check("req_b", 32'(calc_bus.operand_b), 32'h0007);
    check("req_op", 32'(calc_bus.op), 32'h0);
    check("req_entry", 32'(entry_bcd), 32'h0007);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (calc_bus.calc_req) h++;
    end
    calc_bus.calc_ready = 1'b1;
    tick();
    calc_bus.calc_ready = 1'b0;
    check("req_high_cycles", 32'(h), 32'd6);
    check_zero("handshake");
    key_down = 1'b0;
    repeat (6) tick();

    // Overflow, then clear key
    do_reset();
    press(4'h9);
    press(4'h8);
    press(4'h7);
    press(4'h6);
    press(4'h5);
    check("ovf_a", 32'(calc_bus.operand_a), 32'h9876);
    check("ovf_entry", 32'(entry_bcd), 32'h9876);
    check("ovf_flag", 32'(entry_ovf), 32'h1);
    press(KEY_CLR);
`ifdef ENTRY_BACKSPACE_EN
    check("bksp_entry", 32'(entry_bcd), 32'h0987);
    check("bksp_a", 32'(calc_bus.operand_a), 32'h0987);
    check("bksp_ovf", 32'(entry_ovf), 32'h0);
`else
    check_zero("clear");
`endif

    // 5 + - 3 * : second operator replaces, third ignored
    do_reset();
    press(4'h5);
    press(KEY_ADD);
    press(KEY_SUB);
    press(4'h3);
    press(KEY_MUL);
    check("ops_op", 32'(calc_bus.op), 32'h1);
    check("ops_b", 32'(calc_bus.operand_b), 32'h0003);
    check("ops_a", 32'(calc_bus.operand_a), 32'h0005);
    check("ops_entry", 32'(entry_bcd), 32'h0003);

    // Asynchronous reset while a request is pending
    press(KEY_EQ);
    check("pend_req", 32'(calc_bus.calc_req), 32'h1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-press: held key gives exactly one event afterwards
    key_code = 4'h1;
    key_down = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (DB) tick();
    check("midrst_before", 32'(entry_bcd), 32'h0);
    tick();
    check("midrst_after", 32'(entry_bcd), 32'h1);
    repeat (6) tick();
    key_down = 1'b0;
    repeat (6) tick();
    check("midrst_norepeat", 32'(entry_bcd), 32'h1);

    // Clear key aborts a pending request
    press(KEY_ADD);
    press(4'h2);
    press(KEY_EQ);
    check("abort_req", 32'(calc_bus.calc_req), 32'h1);
    press(KEY_CLR);
    check_zero("abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Consumer side of the keypad scanner interface.
- Debounces the scanner's key code and turns each physical press into exactly one key event.
- Assembles decimal BCD operands and an operator from those events.
- Presents a complete A-op-B request to the calculator core with a req/ready handshake, and feeds the operand being edited to the 7-segment display decoders.

Parameters:
DIGITS, 4, maximum BCD digits per operand; operand width is 4*DIGITS.
DEBOUNCE_CYCLES, 1000, consecutive stable clk cycles required to accept a press or a release.

Ports:
clk  input  1  system clock; all state is updated on its rising edge.
rst  input  1  asynchronous reset, active-high.
key_code  input  4  code from the keypad scanner: 0-9 digit, A add, B sub, C mul, D div, E clear, F equals.
key_down  input  1  scanner reports a key currently held.
calc_ready  input  1  calculator core accepts the request this cycle.
calc_req  output  1  request valid.
operand_a  output  4*DIGITS  BCD operand A, least significant digit in bits [3:0].
operand_b  output  4*DIGITS  BCD operand B.
op  output  2  operator: 0 add, 1 sub, 2 mul, 3 div.
entry_bcd  output  4*DIGITS  operand currently being edited, for the display.
entry_ovf  output  1  sticky: a digit was dropped because the operand was full.

Behaviour:
- Reset (async, rst=1): every output is 0, FSM is in S_A, digit counts are 0, debouncer is in RELEASED.
- Debouncer states:
  - RELEASED: moves to PRESSED after key_down=1 with an unchanged key_code for DEBOUNCE_CYCLES consecutive cycles. Any change of key_code or key_down restarts the count.
  - PRESSED: moves to RELEASED after key_down=0 for DEBOUNCE_CYCLES consecutive cycles.
  - The RELEASED->PRESSED transition emits a one-cycle internal event carrying key_code.
  - Minimum latency from key_down rising to the action taking effect is DEBOUNCE_CYCLES+1 cycles.
  - Holding a key never produces repeat events.
- Digit event (code 0-9):
  - Target is A in S_A and B in S_B.
  - If target count < DIGITS: target <= {target[4*DIGITS-5:0], code} and count increments.
  - Otherwise the digit is dropped and entry_ovf is set.
  - Leading zeros are counted as digits.
- Operator event (codes A-D):
  - In S_A: op <= code-0xA and the FSM moves to S_B. An empty A is a valid 0.
  - In S_B with B count 0: op is replaced.
  - In S_B with B count > 0: the event is ignored.
- Equals event (code F):
  - In S_B: moves to S_REQ with calc_req=1 from the next cycle. An empty B is 0.
  - In S_A: ignored.
- S_REQ:
  - operand_a, operand_b and op are frozen. calc_req stays high until a cycle where calc_req=1 and calc_ready=1.
  - In that same cycle, the next state is S_A with operands, counts, op and entry_ovf all cleared; calc_req=0 from the next cycle.
  - Digit, operator and equals events are ignored in S_REQ.
- Clear event (code E): in any state, including S_REQ (aborting the request), clears everything back to reset values except the debouncer.
- entry_bcd: equals operand_a in S_A, and operand_b in S_B and S_REQ. Registered, same cycle as the operand update.
- Simultaneous events: a key event and calc_ready in the same cycle of S_REQ: the handshake completes and the key event is dropped, except E, which has no extra effect because state is cleared either way.
- Reset mid-press: the debouncer returns to RELEASED. A key still held after reset deasserts produces one event after DEBOUNCE_CYCLES.

Optional Feature:
ENTRY_BACKSPACE_EN
- Defined: E with the current target count > 0 in S_A/S_B deletes the last digit (target >> 4, count decrements, entry_ovf cleared).
- Defined: E with count 0, or E in S_REQ, performs the full clear.
- Not defined: E is always a full clear.

Decomposition:
- Package keypad_pkg:
  - key code constants (KEY_ADD=4'hA, KEY_SUB, KEY_MUL, KEY_DIV, KEY_CLR=4'hE, KEY_EQ=4'hF);
  - op encoding constants;
  - FSM state typedef (S_A, S_B, S_REQ).
- One sub-module, key_debounce (key_code, key_down -> key_evt, key_evt_code). It is reusable by other keypad consumers.

Test Plan (DEBOUNCE_CYCLES=4, DIGITS=4):
- Press 1,2,3 (each held 6 cycles, released 6 cycles) -> entry_bcd=16'h0123, operand_a=16'h0123, one event per press.
- Glitch: key_down high 3 cycles, then low -> no event, entry_bcd unchanged.
- Sequence 4,2,+,7,= with calc_ready=0 for 5 cycles, then 1 -> calc_req high 6 cycles, A=16'h0042, B=16'h0007, op=0; all outputs 0 on the cycle after the handshake.
- Digits 9,8,7,6,5 -> operand_a=16'h9876, entry_ovf=1. Then press E -> all outputs 0 (with ENTRY_BACKSPACE_EN: 16'h0987 and entry_ovf=0).
- Sequence 5,+,-,3,* -> op=1 (the second operator replaces the first; the third is ignored because B has a digit), operand_b=16'h0003.
- rst pulsed while in S_REQ with calc_req=1 -> calc_req=0 and all outputs 0 immediately (asynchronously), FSM in S_A.
